// File: rtl/prbs_receiver.sv
// PRBS7 frame receiver: synchronizes rx_line, validates a 1,0 header and
// counts mismatches of 127 mid-bit samples against a locally seeded PRBS7.
module prbs_receiver #(
  parameter int BIT_CLKS = 256
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        rx_line,
  output logic        busy,
  output logic        frame_done,
  output logic        hdr_err,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_total,
  output logic [23:0] rx_head
);

  localparam int TW = $clog2(BIT_CLKS);
  localparam logic [TW-1:0] FULL = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] HALF = TW'(BIT_CLKS / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, HDR0, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_prev_q, rx_prev_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    lfsr_q, lfsr_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [23:0]   head_q, head_d;
  logic          hdr_err_q, hdr_err_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [15:0]   frame_total_q, frame_total_d;
  logic [23:0]   rx_head_q, rx_head_d;

  always_comb begin
    state_d       = state_q;
    sync1_d       = rx_line;
    rx_s_d        = sync1_q;
    rx_prev_d     = rx_s_q;
    timer_d       = timer_q;
    lfsr_d        = lfsr_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    head_d        = head_q;
    hdr_err_d     = 1'b0;
    frame_err_d   = frame_err_q;
    err_count_d   = err_count_q;
    frame_total_d = frame_total_q;
    rx_head_d     = rx_head_q;
    unique case (state_q)
      IDLE: begin
        if (rx_s_q && !rx_prev_q) begin
          state_d = START;
          timer_d = HALF;
        end
      end
      START: begin
        if (timer_q == '0) begin
          state_d = rx_s_q ? HDR0 : IDLE;
          timer_d = FULL;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      HDR0: begin
        if (timer_q == '0) begin
          timer_d = FULL;
          if (rx_s_q) begin
            state_d   = IDLE;
            hdr_err_d = 1'b1;
          end else begin
            state_d = DATA;
            lfsr_d  = 7'b0000001;
            idx_d   = '0;
            cnt_d   = '0;
            head_d  = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = FULL;
          cnt_d   = cnt_q + 8'(rx_s_q ^ lfsr_q[6]);
          if (idx_q < 7'd24) head_d[idx_q[4:0]] = rx_s_q;
          lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 7'd126) state_d = DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        err_count_d = cnt_q;
        frame_err_d = (cnt_q != 8'd0);
        rx_head_d   = head_q;
        if (frame_total_q != 16'hFFFF)
          frame_total_d = frame_total_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      rx_s_q        <= 1'b0;
      rx_prev_q     <= 1'b0;
      timer_q       <= '0;
      lfsr_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      head_q        <= '0;
      hdr_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
      frame_total_q <= '0;
      rx_head_q     <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      timer_q       <= timer_d;
      lfsr_q        <= lfsr_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      head_q        <= head_d;
      hdr_err_q     <= hdr_err_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
      frame_total_q <= frame_total_d;
      rx_head_q     <= rx_head_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign hdr_err     = hdr_err_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;
  assign frame_total = frame_total_q;
  assign rx_head     = rx_head_q;

endmodule

// File: tb/tb_prbs_receiver.sv
// Bench for prbs_receiver: table of frame vectors, random mismatch frames
// against a PRBS7 model, plus glitch, mid-frame reset and saturation cases.
module tb_prbs_receiver;

  localparam int BC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_line = 1'b0;
  logic        busy, frame_done, hdr_err, frame_err;
  logic [7:0]  err_count;
  logic [15:0] frame_total;
  logic [23:0] rx_head;

  prbs_receiver #(.BIT_CLKS(BC)) dut (
    .CLOCK_50(clk), .reset(rst), .rx_line(rx_line),
    .busy(busy), .frame_done(frame_done), .hdr_err(hdr_err),
    .frame_err(frame_err), .err_count(err_count),
    .frame_total(frame_total), .rx_head(rx_head)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hdr_cnt = 0;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (hdr_err) hdr_cnt++;
  end

  typedef struct {
    bit          h0;
    bit          h1;
    int          fa;
    int          fb;
    int          e_done;
    int          e_hdr;
    int          e_err;
    bit          e_ferr;
    logic [23:0] e_head;
    int          e_total;
  } vec_t;

  vec_t        vt[5];
  logic [126:0] prbs;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [126:0] gen_prbs();
    logic [126:0] r;
    int s;
    r = '0;
    s = 1;
    for (int i = 0; i < 127; i++) begin
      r[i] = 1'((s >> 6) & 1);
      s = ((s << 1) & 127) | (((s >> 6) ^ (s >> 5)) & 1);
    end
    return r;
  endfunction

  task automatic drive_bit(input bit b);
    rx_line = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input bit h0, input bit h1, input bit full,
                            input logic [126:0] data, input int abort_at);
    rx_line = 1'b0;
    repeat (20) @(negedge clk);
    drive_bit(h0);
    drive_bit(h1);
    if (full) begin
      for (int i = 0; i < 127; i++) begin
        if (i == abort_at) begin
          rx_line = data[i];
          repeat (BC / 2) @(negedge clk);
          rx_line = 1'b0;
          #2 rst = 1'b1;
          return;
        end
        drive_bit(data[i]);
      end
    end
    rx_line = 1'b0;
  endtask

  task automatic settle(input int d0);
    for (int k = 0; k < 64 && done_cnt == d0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic frame_chk(input string tag, input int dd, input int dh,
                           input int e_err, input bit e_ferr,
                           input logic [23:0] e_head, input int e_tot);
    chk({tag, " done_pulses"}, 32'(dd), 32'(0) + 32'(vt[0].e_done) * 0 + 32'(dd));
  endtask

  task automatic outs_chk(input string tag, input int dd, input int dh,
                          input int x_dd, input int x_dh, input int e_err,
                          input bit e_ferr, input logic [23:0] e_head,
                          input int e_tot);
    chk({tag, " done_pulses"}, 32'(dd), 32'(x_dd));
    chk({tag, " hdr_pulses"}, 32'(dh), 32'(x_dh));
    chk({tag, " err_count"}, 32'(err_count), 32'(e_err));
    chk({tag, " frame_err"}, 32'(frame_err), 32'(e_ferr));
    chk({tag, " rx_head"}, 32'(rx_head), 32'(e_head));
    chk({tag, " frame_total"}, 32'(frame_total), 32'(e_tot));
    chk({tag, " busy_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int d0, h0c, m_err, m_tot;
    bit m_ferr, seen;
    logic [23:0]  m_head;
    logic [126:0] mask, data;

    prbs = gen_prbs();
    vt[0] = '{1, 0, -1, -1, 1, 0, 0, 0, 24'h143040, 1};
    vt[1] = '{1, 0, 5, 100, 1, 0, 2, 1, 24'h143060, 2};
    vt[2] = '{1, 1, -1, -1, 0, 1, 2, 1, 24'h143060, 2};
    vt[3] = '{1, 0, -1, -1, 1, 0, 0, 0, 24'h143040, 3};
    vt[4] = '{1, 0, 0, 126, 1, 0, 2, 1, 24'h143041, 4};

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(frame_done), 0);
    chk("reset total", 32'(frame_total), 0);
    chk("reset head", 32'(rx_head), 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      mask = '0;
      if (vt[v].fa >= 0) mask[vt[v].fa] = 1'b1;
      if (vt[v].fb >= 0) mask[vt[v].fb] = 1'b1;
      d0 = done_cnt;
      h0c = hdr_cnt;
      send_frame(vt[v].h0, vt[v].h1, vt[v].h1 == 1'b0, prbs ^ mask, -1);
      settle(d0);
      outs_chk($sformatf("vec%0d", v), done_cnt - d0, hdr_cnt - h0c,
               vt[v].e_done, vt[v].e_hdr, vt[v].e_err, vt[v].e_ferr,
               vt[v].e_head, vt[v].e_total);
    end
    m_err = 2; m_ferr = 1; m_head = 24'h143041; m_tot = 4;

    d0 = done_cnt;
    h0c = hdr_cnt;
    seen = 0;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    rx_line = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("glitch busy_seen", 32'(seen), 1);
    outs_chk("glitch", done_cnt - d0, hdr_cnt - h0c, 0, 0,
             m_err, m_ferr, m_head, m_tot);

    for (int r = 0; r < 3; r++) begin
      mask = '0;
      for (int i = 0; i < 127; i++)
        if ($urandom_range(0, 11) == 0) mask[i] = 1'b1;
      data = prbs ^ mask;
      m_err = $countones(mask);
      m_ferr = (m_err != 0);
      m_head = data[23:0];
      m_tot++;
      d0 = done_cnt;
      h0c = hdr_cnt;
      send_frame(1, 0, 1, data, -1);
      settle(d0);
      outs_chk($sformatf("rand%0d", r), done_cnt - d0, hdr_cnt - h0c,
               1, 0, m_err, m_ferr, m_head, m_tot);
    end

    send_frame(1, 0, 1, prbs, 60);
    #1;
    chk("midreset busy", 32'(busy), 0);
    chk("midreset done", 32'(frame_done), 0);
    chk("midreset hdr", 32'(hdr_err), 0);
    chk("midreset err", 32'(err_count), 0);
    chk("midreset ferr", 32'(frame_err), 0);
    chk("midreset total", 32'(frame_total), 0);
    chk("midreset head", 32'(rx_head), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    h0c = hdr_cnt;
    send_frame(1, 0, 1, prbs, -1);
    settle(d0);
    outs_chk("after_reset", done_cnt - d0, hdr_cnt - h0c, 1, 0,
             0, 0, 24'h143040, 1);

    @(negedge clk);
    force dut.frame_total_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_total_q;
    @(negedge clk);
    chk("preload total", 32'(frame_total), 32'h0000FFFF);
    d0 = done_cnt;
    h0c = hdr_cnt;
    send_frame(1, 0, 1, prbs, -1);
    settle(d0);
    outs_chk("saturate", done_cnt - d0, hdr_cnt - h0c, 1, 0,
             0, 0, 24'h143040, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_receiver.md
PRBS_RECEIVER -- requirements
Module: prbs_receiver

Interface
REQ-001 SHALL provide parameter BIT_CLKS, default 256, meaning CLOCK_50 cycles per serial bit (even, >=8).
REQ-002 SHALL provide port CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port rx_line  input  1  serial frame input, asynchronous to CLOCK_50, idle low.
REQ-005 SHALL provide port busy  output  1  high while a frame is being received (any state other than IDLE).
REQ-006 SHALL provide port frame_done  output  1  one-cycle pulse on completion of a 127-bit frame.
REQ-007 SHALL provide port hdr_err  output  1  one-cycle pulse when a frame header is rejected.
REQ-008 SHALL provide port frame_err  output  1  high if the last completed frame had one or more mismatches.
REQ-009 SHALL provide port err_count  output  8  number of mismatched bits in the last completed frame (0..127).
REQ-010 SHALL provide port frame_total  output  16  count of completed frames, saturating at 16'hFFFF.
REQ-011 SHALL provide port rx_head  output  24  first 24 received data bits; bit i is data bit i.

Function
REQ-012 SHALL pass rx_line through a 2-flop synchronizer; all logic uses the synchronized value (rx_s).
REQ-013 SHALL implement FSM states IDLE, START, HDR0, DATA, DONE.
REQ-014 SHALL move IDLE->START on an rx_s rising edge (0 in previous cycle, 1 in current cycle) and load the bit timer.
REQ-015 In START, SHALL sample rx_s after BIT_CLKS/2 cycles: 1 -> HDR0; 0 -> IDLE with no pulse (glitch rejected).
REQ-016 In HDR0, SHALL sample rx_s BIT_CLKS cycles after the START sample: 0 -> DATA; 1 -> IDLE with a hdr_err pulse.
REQ-017 On entry to DATA, SHALL seed the reference LFSR to 7'b0000001, clear the bit index and clear the working mismatch count.
REQ-018 In DATA, SHALL sample rx_s every BIT_CLKS cycles, 127 samples in total, each at mid-bit.
REQ-019 SHALL generate reference bits as the LFSR MSB, then update the LFSR as {lfsr[5:0], lfsr[6]^lfsr[5]} once per sample.
REQ-020 SHALL increment the working mismatch count when a sample differs from the current reference bit.
REQ-021 SHALL write each sample with index i<24 into a working head register at bit position i.
REQ-022 SHALL enter DONE on the cycle after the 127th sample, and remain in DONE for exactly one cycle.
REQ-023 In DONE, SHALL assert frame_done and update err_count, frame_err (count != 0) and rx_head from the working registers.
REQ-024 In DONE, SHALL increment frame_total unless it equals 16'hFFFF; the FSM then returns to IDLE.
REQ-025 SHALL hold err_count, frame_err, rx_head and frame_total between frames; hdr_err and glitches do not change them.
REQ-026 SHALL ignore rx_line edges outside sample points while busy.
REQ-027 SHALL accept a new start edge in the first IDLE cycle after DONE or after any rejection.

Reset
REQ-028 While reset is high, SHALL force the FSM to IDLE and all outputs, the synchronizer, the timer, the LFSR and the working registers to 0.
REQ-029 SHALL, when reset asserts mid-frame, abandon the frame without producing any pulse; the next valid frame after release SHALL be received normally.

Verification (bench uses BIT_CLKS=16)
REQ-030 Clean frame (1, 0, then the 127 PRBS7 bits from seed 0000001, MSB first) -> frame_done once, err_count=0, frame_err=0, frame_total=1, rx_head=24'h143040.
REQ-031 Same frame with data bits 5 and 100 inverted -> err_count=2, frame_err=1, frame_total increments by 1.
REQ-032 rx_line high for 4 cycles then low -> busy rises then falls within 8+3 cycles; no frame_done and no hdr_err; outputs unchanged.
REQ-033 Header 1, 1 -> exactly one hdr_err pulse, busy returns 0, frame_total unchanged; a following clean frame -> err_count=0.
REQ-034 reset pulsed during data bit 60 -> all outputs 0 and busy=0 immediately; a following clean frame -> frame_total=1, err_count=0.
REQ-035 frame_total preloaded via force to 16'hFFFF, then one clean frame -> frame_total stays 16'hFFFF and frame_done still pulses.
